hc_csr_bank: RTL
================

Name: hc_csr_bank

Overview:
- Parametrised HardCloud MMIO CSR bank: decodes CCI-P MMIO writes and reads into a DSM base register, a control FSM and an N-entry buffer table of address/size pairs.
- Successor to the fixed two-buffer, write-only decode: adds a parametrised buffer count, MMIO read-back with TID echo, per-buffer valid tracking, a status register and a run-cycle counter.
- Sits between the CCI-P c0 MMIO channel and the accelerator datapath's read/write FSMs.

Parameters:
- NUM_BUFFERS, 4, number of buffer-table entries (1..16).
- DSM_ADDR, 16'h110, byte address of the DSM base register.
- CONTROL_ADDR, 16'h118, byte address of the control register.
- STATUS_ADDR, 16'h100, byte address of the status register (read-only).
- CYCLES_ADDR, 16'h108, byte address of the run-cycle counter (read-only).
- BUFFER_BASE, 16'h120, byte address of buffer 0; entry i address at BUFFER_BASE+16*i, size at BUFFER_BASE+16*i+8.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- mmio_wr_valid  in  1  MMIO write strobe.
- mmio_rd_valid  in  1  MMIO read strobe.
- mmio_addr  in  16  MMIO dword address (byte address >> 2).
- mmio_tid  in  9  read transaction ID.
- mmio_wr_data  in  64  write data.
- mmio_rd_rsp_valid  out  1  read response valid.
- mmio_rd_rsp_tid  out  9  echoed TID.
- mmio_rd_rsp_data  out  64  read data.
- dsm_base  out  64  DSM base address.
- buffer_addr  out  NUM_BUFFERS*42  cache-line addresses; entry i at [42*i +: 42].
- buffer_size  out  NUM_BUFFERS*32  sizes; entry i at [32*i +: 32].
- buffer_valid  out  NUM_BUFFERS  entry has both address and size written since last reset.
- accel_rst_n  out  1  accelerator reset, active low.
- accel_start  out  1  one-cycle start pulse.
- accel_running  out  1  high in S_RUN.
- accel_done  in  1  accelerator completion, sampled in S_RUN.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all registers and outputs 0; state S_RESET; accel_rst_n=0.
  - A response pending at reset is dropped.
- Writes (mmio_wr_valid=1): addr==DSM_ADDR>>2 loads dsm_base=data[63:0].
- Writes, buffer entries:
  - entry i address word: buffer_addr_i=data[41:0], sets addr_written_i.
  - entry i size word: buffer_size_i=data[31:0], sets size_written_i.
  - buffer_valid_i = addr_written_i & size_written_i.
  - Buffer writes in S_RUN are ignored and set sticky err.
- Writes to STATUS, CYCLES or unmapped addresses are ignored. All register updates are visible the cycle after the write.
- Reads:
  - Registered, latency exactly 1: response in cycle N+1 for a read in cycle N, with tid echoed and valid high for that one cycle.
  - STATUS = {32'b0, 16'(buffer_valid), 12'b0, err, done, state[1:0]}.
  - CONTROL reads the last value written.
  - Unmapped addresses return 0.
  - Back-to-back reads produce back-to-back responses.
  - If mmio_wr_valid and mmio_rd_valid are both high in one cycle: the write is applied and the read returns the pre-write value.
- Control FSM (state encoding S_RESET=0, S_IDLE=1, S_RUN=2, S_DONE=3); transitions are evaluated on CONTROL writes.
  - 32'h0 from any state -> S_RESET: clears done, err, cycles and all written/valid flags; buffer and DSM register contents are retained.
  - 32'h1 from S_RESET -> S_IDLE; accel_rst_n=1 in every state except S_RESET.
  - 32'h3 from S_IDLE or S_DONE with buffer_valid all ones -> S_RUN: accel_start pulses for the first S_RUN cycle, cycles cleared to 0, done cleared.
  - 32'h3 with any buffer_valid bit 0, or from S_RESET -> no transition, err=1.
  - 32'h7 from S_RUN -> S_IDLE (abort; done stays 0).
  - Any other value, or a valid code illegal in the current state -> no transition, err=1.
- accel_done=1 in S_RUN -> S_DONE next cycle, done=1.
- A CONTROL write in the same cycle as accel_done has priority over accel_done.
- cycles: 32-bit counter, increments each S_RUN cycle, saturates at 32'hFFFFFFFF, holds in other states.

Test Plan:
- Reset, then read STATUS tid=9'h05 -> one cycle later rsp_valid=1, tid=9'h05, data=0, accel_rst_n=0.
- Write DSM 64'h0000_1234_5678_9ABC, read DSM -> returns 64'h0000_1234_5678_9ABC, dsm_base matches.
- NUM_BUFFERS=4; ctrl=1; write addr and size for entries 0..2 only; ctrl=3 -> state stays S_IDLE, err=1, STATUS[19:16]=4'b0111, no start pulse.
- Write entry 3 (addr 42'h3FF, size 32'd4096), ctrl=3 -> accel_start high exactly 1 cycle, state=2; after 10 cycles assert accel_done -> state=3, CYCLES reads 10±1 per the defined count, done=1.
- In S_RUN write entry 1 size -> value unchanged, err=1; ctrl=7 -> S_IDLE, done=0.
- Simultaneous write CONTROL=0 and read STATUS in S_DONE -> response shows state=3 with done set; a subsequent read shows state=0 and all valid bits clear.

Source files
------------

// File: rtl/hc_csr_bank.sv
// -----------------------------------------------------------------------------
// hc_csr_bank
// HardCloud MMIO CSR bank. Decodes CCI-P c0 MMIO writes and reads into a DSM
// base register, a control FSM driving the accelerator reset/start handshake,
// and an N-entry buffer table of cache-line address / size pairs.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   mmio_wr_valid/rd_valid MMIO write / read strobes
//   mmio_addr             MMIO dword address (byte address >> 2)
//   mmio_tid              read transaction ID, echoed on the response
//   mmio_wr_data          write data
//   mmio_rd_rsp_*         registered read response (latency 1)
//   dsm_base              DSM base address
//   buffer_addr/size      flattened buffer table, entry i at [42*i +: 42] / [32*i +: 32]
//   buffer_valid          entry i has had both address and size written
//   accel_rst_n           accelerator reset, low only in S_RESET
//   accel_start           one-cycle pulse on entry to S_RUN
//   accel_running         high while in S_RUN
//   accel_done            accelerator completion, sampled in S_RUN
// -----------------------------------------------------------------------------
module hc_csr_bank #(
    parameter int          NUM_BUFFERS  = 4,
    parameter logic [15:0] DSM_ADDR     = 16'h110,
    parameter logic [15:0] CONTROL_ADDR = 16'h118,
    parameter logic [15:0] STATUS_ADDR  = 16'h100,
    parameter logic [15:0] CYCLES_ADDR  = 16'h108,
    parameter logic [15:0] BUFFER_BASE  = 16'h120
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mmio_wr_valid,
    input  logic                      mmio_rd_valid,
    input  logic [15:0]               mmio_addr,
    input  logic [8:0]                mmio_tid,
    input  logic [63:0]               mmio_wr_data,
    output logic                      mmio_rd_rsp_valid,
    output logic [8:0]                mmio_rd_rsp_tid,
    output logic [63:0]               mmio_rd_rsp_data,
    output logic [63:0]               dsm_base,
    output logic [NUM_BUFFERS*42-1:0] buffer_addr,
    output logic [NUM_BUFFERS*32-1:0] buffer_size,
    output logic [NUM_BUFFERS-1:0]    buffer_valid,
    output logic                      accel_rst_n,
    output logic                      accel_start,
    output logic                      accel_running,
    input  logic                      accel_done
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_IDLE  = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Register map in dword units, matching mmio_addr.
    localparam logic [15:0] DSM_DW    = DSM_ADDR >> 2;
    localparam logic [15:0] CONTROL_DW = CONTROL_ADDR >> 2;
    localparam logic [15:0] STATUS_DW = STATUS_ADDR >> 2;
    localparam logic [15:0] CYCLES_DW = CYCLES_ADDR >> 2;
    localparam logic [15:0] BUFFER_DW = BUFFER_BASE >> 2;

    // Entry i spans 16 bytes (4 dwords): address word first, size word at +8 bytes.
    function automatic logic [15:0] buf_dw(input int idx, input logic is_size);
        return BUFFER_DW + 16'(4 * idx) + (is_size ? 16'd2 : 16'd0);
    endfunction

    state_e                  state_q,     state_d;
    logic                    err_q,       err_d;
    logic                    done_q,      done_d;
    logic                    start_q,     start_d;
    logic [31:0]             cycles_q,    cycles_d;
    logic [63:0]             dsm_q,       dsm_d;
    logic [63:0]             ctrl_q,      ctrl_d;
    logic [NUM_BUFFERS-1:0]  addr_wr_q,   addr_wr_d;
    logic [NUM_BUFFERS-1:0]  size_wr_q,   size_wr_d;
    logic [41:0]             buf_addr_q [NUM_BUFFERS];
    logic [41:0]             buf_addr_d [NUM_BUFFERS];
    logic [31:0]             buf_size_q [NUM_BUFFERS];
    logic [31:0]             buf_size_d [NUM_BUFFERS];
    logic                    rsp_valid_q, rsp_valid_d;
    logic [8:0]              rsp_tid_q,   rsp_tid_d;
    logic [63:0]             rsp_data_q,  rsp_data_d;
    logic                    ctrl_wr;

    assign buffer_valid = addr_wr_q & size_wr_q;
    assign ctrl_wr      = mmio_wr_valid && (mmio_addr == CONTROL_DW);

    // NOTE: combinational logic uses blocking '=' and gives every target a
    // default first, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        done_d      = done_q;
        start_d     = 1'b0;
        cycles_d    = cycles_q;
        dsm_d       = dsm_q;
        ctrl_d      = ctrl_q;
        addr_wr_d   = addr_wr_q;
        size_wr_d   = size_wr_q;
        buf_addr_d  = buf_addr_q;
        buf_size_d  = buf_size_q;
        rsp_valid_d = mmio_rd_valid;
        rsp_tid_d   = mmio_rd_valid ? mmio_tid : rsp_tid_q;
        rsp_data_d  = rsp_data_q;

        // Read mux works on current register values, so a read coinciding with
        // a write returns the pre-write contents.
        if (mmio_rd_valid) begin
            rsp_data_d = 64'h0;
            if (mmio_addr == STATUS_DW)
                rsp_data_d = {32'b0, 16'(buffer_valid), 12'b0, err_q, done_q, state_q};
            else if (mmio_addr == CYCLES_DW)
                rsp_data_d = {32'b0, cycles_q};
            else if (mmio_addr == DSM_DW)
                rsp_data_d = dsm_q;
            else if (mmio_addr == CONTROL_DW)
                rsp_data_d = ctrl_q;
            for (int i = 0; i < NUM_BUFFERS; i++) begin
                if (mmio_addr == buf_dw(i, 1'b0)) rsp_data_d = {22'b0, buf_addr_q[i]};
                if (mmio_addr == buf_dw(i, 1'b1)) rsp_data_d = {32'b0, buf_size_q[i]};
            end
        end

        if (state_q == S_RUN && cycles_q != 32'hFFFF_FFFF)
            cycles_d = cycles_q + 32'd1;

        // A CONTROL write in the same cycle takes priority over completion.
        if (state_q == S_RUN && accel_done && !ctrl_wr) begin
            state_d = S_DONE;
            done_d  = 1'b1;
        end

        if (mmio_wr_valid) begin
            if (mmio_addr == DSM_DW)
                dsm_d = mmio_wr_data;

            if (ctrl_wr) begin
                ctrl_d = mmio_wr_data;
                case (mmio_wr_data)
                    64'h0: begin
                        state_d   = S_RESET;
                        done_d    = 1'b0;
                        err_d     = 1'b0;
                        cycles_d  = 32'h0;
                        addr_wr_d = '0;
                        size_wr_d = '0;
                    end
                    64'h1: begin
                        if (state_q == S_RESET) state_d = S_IDLE;
                        else                    err_d   = 1'b1;
                    end
                    64'h3: begin
                        if ((state_q == S_IDLE || state_q == S_DONE) && (&buffer_valid)) begin
                            state_d  = S_RUN;
                            start_d  = 1'b1;
                            cycles_d = 32'h0;
                            done_d   = 1'b0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    64'h7: begin
                        if (state_q == S_RUN) begin
                            state_d = S_IDLE;
                            done_d  = 1'b0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    default: err_d = 1'b1;
                endcase
            end

            // The datapath reads the table while running, so it is locked in S_RUN.
            for (int i = 0; i < NUM_BUFFERS; i++) begin
                if (mmio_addr == buf_dw(i, 1'b0)) begin
                    if (state_q == S_RUN) begin
                        err_d = 1'b1;
                    end else begin
                        buf_addr_d[i] = mmio_wr_data[41:0];
                        addr_wr_d[i]  = 1'b1;
                    end
                end
                if (mmio_addr == buf_dw(i, 1'b1)) begin
                    if (state_q == S_RUN) begin
                        err_d = 1'b1;
                    end else begin
                        buf_size_d[i] = mmio_wr_data[31:0];
                        size_wr_d[i]  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_RESET;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            start_q     <= 1'b0;
            cycles_q    <= 32'h0;
            dsm_q       <= 64'h0;
            ctrl_q      <= 64'h0;
            addr_wr_q   <= '0;
            size_wr_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_tid_q   <= 9'h0;
            rsp_data_q  <= 64'h0;
            // NOTE: the buffer table is a handful of flops, not a RAM, and the
            // bank must read back 0 after reset, so every entry is cleared here.
            for (int i = 0; i < NUM_BUFFERS; i++) begin
                buf_addr_q[i] <= 42'h0;
                buf_size_q[i] <= 32'h0;
            end
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            done_q      <= done_d;
            start_q     <= start_d;
            cycles_q    <= cycles_d;
            dsm_q       <= dsm_d;
            ctrl_q      <= ctrl_d;
            addr_wr_q   <= addr_wr_d;
            size_wr_q   <= size_wr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tid_q   <= rsp_tid_d;
            rsp_data_q  <= rsp_data_d;
            buf_addr_q  <= buf_addr_d;
            buf_size_q  <= buf_size_d;
        end
    end

    for (genvar g = 0; g < NUM_BUFFERS; g++) begin : g_flat
        assign buffer_addr[42*g +: 42] = buf_addr_q[g];
        assign buffer_size[32*g +: 32] = buf_size_q[g];
    end

    assign mmio_rd_rsp_valid = rsp_valid_q;
    assign mmio_rd_rsp_tid   = rsp_tid_q;
    assign mmio_rd_rsp_data  = rsp_data_q;
    assign dsm_base          = dsm_q;
    assign accel_rst_n       = (state_q != S_RESET);
    assign accel_start       = start_q;
    assign accel_running     = (state_q == S_RUN);

endmodule
